// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer with up to NUM_REQS outstanding bus requests and a response FIFO.
// Optional discard statistics counter enabled by defining IBEX_PREFETCH_DISCARD_CNT_EN.
module ibex_prefetch_buffer_nreq #(
    parameter int NUM_REQS   = 2,
    parameter int FIFO_DEPTH = 3,
    parameter bit ResetAll   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    ,
    output logic [15:0] discard_cnt_o
`endif
);

    localparam logic [2:0] NumReqs = 3'(NUM_REQS);
    localparam logic [4:0] Depth   = 5'(FIFO_DEPTH);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e      state_q, state_d;
    logic [2:0]  out_cnt_q, out_cnt_d;
    logic [2:0]  disc_cnt_q, disc_cnt_d;
    logic [3:0]  fifo_cnt_q, fifo_cnt_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [32:0] fifo_q [FIFO_DEPTH];
    logic [32:0] fifo_d [FIFO_DEPTH];

    logic [31:0] branch_addr;
    logic        rvalid, gnt, issue, can_issue;
    logic        drop, push, pop;
    logic [3:0]  wr_idx;

    assign branch_addr = addr_i & 32'hFFFF_FFFC;
    // Responses with nothing outstanding are ignored, so stale traffic after reset never lands.
    assign rvalid      = instr_rvalid_i & (out_cnt_q != 3'd0);
    assign can_issue   = req_i & (out_cnt_q < NumReqs) &
                         ((({2'b00, out_cnt_q} + {1'b0, fifo_cnt_q}) < Depth) | branch_i);

    always_comb begin
        state_d      = state_q;
        instr_req_o  = 1'b0;
        instr_addr_o = req_addr_q;
        issue        = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    issue        = 1'b1;
                    instr_req_o  = 1'b1;
                    instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
                    if (!instr_gnt_i) state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt     = instr_req_o & instr_gnt_i;
    assign drop    = rvalid & (branch_i | (disc_cnt_q != 3'd0));
    assign push    = rvalid & ~drop;
    assign valid_o = (fifo_cnt_q != 4'd0) & ~branch_i;
    assign pop     = valid_o & ready_i;
    assign wr_idx  = fifo_cnt_q - {3'b000, pop};

    always_comb begin
        req_addr_d   = issue ? instr_addr_o : req_addr_q;
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = branch_addr + (issue ? 32'd4 : 32'd0);
        end else if (issue) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end

        out_cnt_d = out_cnt_q + {2'b00, gnt} - {2'b00, rvalid};

        // A request still waiting for grant at branch time is also stale.
        disc_cnt_d = disc_cnt_q;
        if (branch_i) begin
            disc_cnt_d = out_cnt_q - {2'b00, rvalid} + {2'b00, (state_q == WAIT_GNT)};
        end else if (rvalid && (disc_cnt_q != 3'd0)) begin
            disc_cnt_d = disc_cnt_q - 3'd1;
        end

        fifo_cnt_d = branch_i ? 4'd0 : (fifo_cnt_q + {3'b000, push} - {3'b000, pop});

        addr_d = addr_q;
        if (branch_i) begin
            addr_d = branch_addr;
        end else if (pop) begin
            addr_d = addr_q + 32'd4;
        end
    end

    // Shift FIFO: head always sits at entry 0, new words land just above the survivors.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (wr_idx == 4'(i))) fifo_d[i] = {instr_rdata_i, instr_err_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            out_cnt_q    <= 3'd0;
            disc_cnt_q   <= 3'd0;
            fifo_cnt_q   <= 4'd0;
            fetch_addr_q <= 32'd0;
            addr_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            out_cnt_q    <= out_cnt_d;
            disc_cnt_q   <= disc_cnt_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fetch_addr_q <= fetch_addr_d;
            addr_q       <= addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni && ResetAll) begin
            req_addr_q <= 32'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 33'd0;
            end
        end else begin
            req_addr_q <= req_addr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign rdata_o = fifo_q[0][32:1];
    assign err_o   = fifo_q[0][0] & (fifo_cnt_q != 4'd0);
    assign addr_o  = addr_q;
    assign busy_o  = (out_cnt_q != 3'd0) | instr_req_o;

`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    logic [15:0] disc_stat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            disc_stat_q <= 16'd0;
        end else if (drop && (disc_stat_q != 16'hFFFF)) begin
            disc_stat_q <= disc_stat_q + 16'd1;
        end
    end

    assign discard_cnt_o = disc_stat_q;
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
// Directed bench for ibex_prefetch_buffer_nreq (NUM_REQS=2, FIFO_DEPTH=3).
module tb_ibex_prefetch_buffer_nreq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o, err_o;
    logic [31:0] rdata_o, addr_o;
    logic        instr_req_o, instr_gnt_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        instr_err_i, instr_rvalid_i;
    logic        busy_o;
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    logic [15:0] discard_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ibex_prefetch_buffer_nreq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .instr_rvalid_i (instr_rvalid_i),
        .busy_o         (busy_o)
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        ,
        .discard_cnt_o  (discard_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input logic v, input logic [31:0] d, input logic e);
        instr_rvalid_i = v;
        instr_rdata_i  = d;
        instr_err_i    = e;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
        addr_i = 32'd0; instr_gnt_i = 1'b0;
        rsp(1'b0, 32'd0, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // Branch to 0x100 with immediate grants; third request must wait.
        tick();
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h0000_0103; instr_gnt_i = 1'b1;
        #1;
        chk("br_req", 32'(instr_req_o), 32'd1);
        chk("br_addr", instr_addr_o, 32'h100);
        tick();
        branch_i = 1'b0;
        #1;
        chk("seq_addr", instr_addr_o, 32'h104);
        tick();
        chk("max_out_req", 32'(instr_req_o), 32'd0);
        chk("max_out_busy", 32'(busy_o), 32'd1);

        // Responses A, B delivered in order with one-cycle latency.
        ready_i = 1'b1;
        rsp(1'b1, 32'hAAAA_0001, 1'b0);
        #1;
        chk("lat_valid0", 32'(valid_o), 32'd0);
        tick();
        rsp(1'b1, 32'hBBBB_0002, 1'b0);
        #1;
        chk("a_valid", 32'(valid_o), 32'd1);
        chk("a_addr", addr_o, 32'h100);
        chk("a_rdata", rdata_o, 32'hAAAA_0001);
        chk("refill_addr", instr_addr_o, 32'h108);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        req_i = 1'b0; instr_gnt_i = 1'b0;
        #1;
        chk("b_addr", addr_o, 32'h104);
        chk("b_rdata", rdata_o, 32'hBBBB_0002);
        chk("b_err", 32'(err_o), 32'd0);
        tick();
        chk("empty_valid", 32'(valid_o), 32'd0);
        chk("empty_busy", 32'(busy_o), 32'd1);

        // Two outstanding (0x108, 0x10C), then branch to 0x200.
        req_i = 1'b1; instr_gnt_i = 1'b1;
        tick();
        branch_i = 1'b1; addr_i = 32'h200;
        #1;
        chk("br2_req", 32'(instr_req_o), 32'd0);
        tick();
        branch_i = 1'b0;
        rsp(1'b1, 32'hDEAD_0001, 1'b0);
        #1;
        chk("drop1_valid", 32'(valid_o), 32'd0);
        tick();
        rsp(1'b1, 32'hDEAD_0002, 1'b0);
        #1;
        chk("tgt_addr", instr_addr_o, 32'h200);
        chk("tgt_req", 32'(instr_req_o), 32'd1);
        tick();
        req_i = 1'b0; instr_gnt_i = 1'b0;
        rsp(1'b1, 32'hC0DE_0200, 1'b0);
        #1;
        chk("drop2_valid", 32'(valid_o), 32'd0);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        #1;
        chk("tgt_valid", 32'(valid_o), 32'd1);
        chk("tgt_oaddr", addr_o, 32'h200);
        chk("tgt_rdata", rdata_o, 32'hC0DE_0200);
        chk("idle_busy", 32'(busy_o), 32'd0);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        chk("disc_cnt2", 32'(discard_cnt_o), 32'd2);
`endif
        tick();

        // FIFO full with ready low: only three requests (0x204, 0x208, 0x20C).
        ready_i = 1'b0; req_i = 1'b1; instr_gnt_i = 1'b1;
        tick();
        tick();
        rsp(1'b1, 32'h5000_0204, 1'b0);
        tick();
        rsp(1'b1, 32'h5000_0208, 1'b0);
        #1;
        chk("full_issue_addr", instr_addr_o, 32'h20C);
        tick();
        rsp(1'b1, 32'h5000_020C, 1'b0);
        #1;
        chk("full_req0", 32'(instr_req_o), 32'd0);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        #1;
        chk("full_req1", 32'(instr_req_o), 32'd0);
        chk("full_head_addr", addr_o, 32'h204);
        chk("full_head_data", rdata_o, 32'h5000_0204);
        ready_i = 1'b1;
        #1;
        chk("full_req_pop", 32'(instr_req_o), 32'd0);
        tick();
        ready_i = 1'b0; instr_gnt_i = 1'b0;
        #1;
        chk("after_pop_req", 32'(instr_req_o), 32'd1);
        chk("after_pop_addr", instr_addr_o, 32'h210);
        chk("after_pop_head", addr_o, 32'h208);

        // Branch while waiting for grant at 0x210.
        tick();
        branch_i = 1'b1; addr_i = 32'h300;
        #1;
        chk("wg_addr0", instr_addr_o, 32'h210);
        chk("wg_valid_br", 32'(valid_o), 32'd0);
        tick();
        branch_i = 1'b0;
        #1;
        chk("wg_addr1", instr_addr_o, 32'h210);
        chk("wg_req1", 32'(instr_req_o), 32'd1);
        chk("wg_flushed", 32'(valid_o), 32'd0);
        tick();
        instr_gnt_i = 1'b1;
        #1;
        chk("wg_addr2", instr_addr_o, 32'h210);
        tick();
        rsp(1'b1, 32'hBAD0_0210, 1'b0);
        #1;
        chk("wg_next_addr", instr_addr_o, 32'h300);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        req_i = 1'b0; instr_gnt_i = 1'b0;
        #1;
        chk("wg_dropped", 32'(valid_o), 32'd0);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        chk("disc_cnt3", 32'(discard_cnt_o), 32'd3);
`endif
        tick();

        // Error on the middle word (0x304) only.
        req_i = 1'b1; instr_gnt_i = 1'b1;
        rsp(1'b1, 32'h1111_0300, 1'b0);
        tick();
        rsp(1'b1, 32'h2222_0304, 1'b1);
        tick();
        req_i = 1'b0; instr_gnt_i = 1'b0; ready_i = 1'b1;
        rsp(1'b1, 32'h3333_0308, 1'b0);
        #1;
        chk("e0_addr", addr_o, 32'h300);
        chk("e0_err", 32'(err_o), 32'd0);
        chk("e0_rdata", rdata_o, 32'h1111_0300);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        #1;
        chk("e1_addr", addr_o, 32'h304);
        chk("e1_err", 32'(err_o), 32'd1);
        chk("e1_rdata", rdata_o, 32'h2222_0304);
        tick();
        chk("e2_addr", addr_o, 32'h308);
        chk("e2_err", 32'(err_o), 32'd0);
        chk("e2_rdata", rdata_o, 32'h3333_0308);
        tick();
        chk("e_end_valid", 32'(valid_o), 32'd0);
        chk("e_end_busy", 32'(busy_o), 32'd0);

        // Reset with a request in flight; its late response must be ignored.
        req_i = 1'b1; instr_gnt_i = 1'b1;
        tick();
        req_i = 1'b0; instr_gnt_i = 1'b0; rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        rsp(1'b1, 32'hFFFF_0000, 1'b0);
        #1;
        chk("mrst_addr", addr_o, 32'd0);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        tick();
        rsp(1'b0, 32'd0, 1'b0);
        #1;
        chk("mrst_valid", 32'(valid_o), 32'd0);
        chk("mrst_busy2", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
